// File: rtl/icache_loader_if.sv
// ---------------------------------------------------------------------------
// icache_loader_if
// Purpose : groups the load-stream handshake and the i-cache write bus of the
//           i-cache loader into one bundle.
// Signals : byte_i              - incoming load-stream byte
//           byteValid_i         - byte_i is valid this cycle
//           byteReady_o         - loader accepts byte_i this cycle
//           icacheWriteEnable_o - i-cache write strobe
//           writeAddress_o      - i-cache write address
//           instruction_o       - bundle to write
//           loading_o           - frame in progress (core held off)
//           done_o              - one-cycle pulse at frame completion
//           error_o             - one-cycle pulse on a discarded sync byte
// Modports: slave  - the loader (consumes bytes, drives the cache bus)
//           master - the stream source / cache side
// ---------------------------------------------------------------------------
interface icache_loader_if #(
   parameter int INSTR_WIDTH = 60,
   parameter int ADDR_WIDTH  = 16
);
   logic [7:0]             byte_i;
   logic                   byteValid_i;
   logic                   byteReady_o;
   logic                   icacheWriteEnable_o;
   logic [ADDR_WIDTH-1:0]  writeAddress_o;
   logic [INSTR_WIDTH-1:0] instruction_o;
   logic                   loading_o;
   logic                   done_o;
   logic                   error_o;

   modport slave (
      input  byte_i,
      input  byteValid_i,
      output byteReady_o,
      output icacheWriteEnable_o,
      output writeAddress_o,
      output instruction_o,
      output loading_o,
      output done_o,
      output error_o
   );

   modport master (
      output byte_i,
      output byteValid_i,
      input  byteReady_o,
      input  icacheWriteEnable_o,
      input  writeAddress_o,
      input  instruction_o,
      input  loading_o,
      input  done_o,
      input  error_o
   );
endinterface : icache_loader_if

// File: rtl/icache_loader.sv
// ---------------------------------------------------------------------------
// icache_loader
// Purpose : receives a framed byte stream and writes instruction bundles into
//           the i-cache. Frame: 0xA5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then
//           CNT bundles of BPW bytes each, MSB first. Each bundle keeps the
//           low INSTR_WIDTH bits of its BPW*8 assembled bits.
// Ports   : clock_i - sole clock, rising edge
//           reset_i - synchronous, active-low reset
//           bus     - icache_loader_if.slave (stream handshake + cache bus)
// ---------------------------------------------------------------------------
module icache_loader #(
   parameter int INSTR_WIDTH = 60,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic            clock_i,
   input  logic            reset_i,
   icache_loader_if.slave  bus
);

   localparam int         BPW  = (INSTR_WIDTH + 7) / 8;
   localparam int         SW   = BPW * 8;
   localparam int         BCW  = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_next;

   logic [7:0]             r_addr_hi;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [7:0]             r_cnt_hi;
   logic [15:0]            r_count;
   logic [BCW-1:0]         r_byte_cnt;
   logic [SW-1:0]          r_shift;
   logic [ADDR_WIDTH-1:0]  r_wr_addr;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic                   r_error;

   logic                   w_ready_st;
   logic                   w_accept;
   logic                   w_last_byte;
   logic                   w_count_zero;
   logic [SW-1:0]          w_shift_next;

   // Ready depends on state alone, so there is no path from byteValid_i.
   assign w_ready_st   = (r_state != S_WRITE) && (r_state != S_DONE);
   assign w_accept     = bus.byteValid_i && w_ready_st;
   assign w_last_byte  = (r_byte_cnt == LAST_BYTE);
   assign w_count_zero = ({r_cnt_hi, bus.byte_i} == 16'd0);
   assign w_shift_next = (r_shift << 8) | SW'(bus.byte_i);

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: the default assignment first keeps this block free of inferred
   // latches on paths that do not change state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (w_accept && (bus.byte_i == SYNC)) w_next = S_ADDR_HI;
         S_ADDR_HI: if (w_accept) w_next = S_ADDR_LO;
         S_ADDR_LO: if (w_accept) w_next = S_CNT_HI;
         S_CNT_HI:  if (w_accept) w_next = S_CNT_LO;
         S_CNT_LO:  if (w_accept) w_next = w_count_zero ? S_DONE : S_DATA;
         S_DATA:    if (w_accept && w_last_byte) w_next = S_WRITE;
         S_WRITE:   w_next = (r_count == 16'd1) ? S_DONE : S_DATA;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath: header latches, bundle assembly, write-bus registers
   // -------------------------------------------------------------------------
   // NOTE: every datapath register is reset, since the write bus must read
   // zero after reset and an aborted frame must leave nothing half-loaded.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         r_addr_hi  <= '0;
         r_addr     <= '0;
         r_cnt_hi   <= '0;
         r_count    <= '0;
         r_byte_cnt <= '0;
         r_shift    <= '0;
         r_wr_addr  <= '0;
         r_instr    <= '0;
         r_error    <= 1'b0;
      end else begin
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept && (bus.byte_i != SYNC)) r_error <= 1'b1;
            end
            S_ADDR_HI: begin
               if (w_accept) r_addr_hi <= bus.byte_i;
            end
            S_ADDR_LO: begin
               if (w_accept) r_addr <= ADDR_WIDTH'({r_addr_hi, bus.byte_i});
            end
            S_CNT_HI: begin
               if (w_accept) r_cnt_hi <= bus.byte_i;
            end
            S_CNT_LO: begin
               if (w_accept) begin
                  r_count    <= {r_cnt_hi, bus.byte_i};
                  r_byte_cnt <= '0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_shift <= w_shift_next;
                  if (w_last_byte) begin
                     // Load the write bus on the edge entering WRITE so it
                     // shows this bundle during the strobe and holds after.
                     r_byte_cnt <= '0;
                     r_wr_addr  <= r_addr;
                     r_instr    <= w_shift_next[INSTR_WIDTH-1:0];
                  end else begin
                     r_byte_cnt <= r_byte_cnt + BCW'(1);
                  end
               end
            end
            S_WRITE: begin
               // Address wraps naturally at 2^ADDR_WIDTH.
               r_addr  <= r_addr + ADDR_WIDTH'(1);
               r_count <= r_count - 16'd1;
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // Ready is also gated by reset so the source cannot see a ready loader
   // while reset is held.
   assign bus.byteReady_o         = reset_i && w_ready_st;
   assign bus.icacheWriteEnable_o = (r_state == S_WRITE);
   assign bus.writeAddress_o      = r_wr_addr;
   assign bus.instruction_o       = r_instr;
   assign bus.loading_o           = (r_state != S_IDLE);
   assign bus.done_o              = (r_state == S_DONE);
   assign bus.error_o             = r_error;

endmodule : icache_loader
